seg_scan_ctrl: RTL
==================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 50000: clk cycles per digit slot; legal range 2..2^20.
REQ-002 Parameter NUM_DIGITS, fixed at 4: digit slots scanned per frame.
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 load  in  1  one-cycle strobe; capture bcd_in.
REQ-006 bcd_in  in  16  four BCD digits; [3:0] = digit 0 (least significant), [15:12] = digit 3.
REQ-007 blank_lz  in  1  level; 1 = blank leading zeros.
REQ-008 load_ack  out  1  one-cycle pulse: value accepted into the shadow register.
REQ-009 dig_bcd  out  4  BCD code for the shared external decoder; [3] = MSB.
REQ-010 digit_en_n  out  4  active-low digit enables, at most one bit low.
REQ-011 frame_done  out  1  one-cycle pulse at slot-index wrap 3->0.
REQ-012 bcd_err  out  1  sticky flag: active value holds a code >9.

Function
REQ-013 Prescaler counts 0..CLK_DIV-1 and wraps; a tick occurs on the cycle where the count equals CLK_DIV-1.
REQ-014 Slot index idx (2 bits) advances by 1 on each tick, wrapping 3->0.
REQ-015 dig_bcd = active[idx]; it is registered and changes in the same cycle as idx.
REQ-016 digit_en_n[idx] = 0 and the other bits = 1, unless the slot is blanked (REQ-017/018); a blanked slot drives all bits 1.
REQ-017 Leading-zero blanking: with blank_lz=1, slot k>0 is blanked when active digits k..3 are all 0; digit 0 is never blanked by this rule.
REQ-018 A slot whose active code is >9 is blanked, and dig_bcd is forced to 4'h0 for that slot.
REQ-019 load=1 writes bcd_in into the shadow register, sets pending, and asserts load_ack on the next cycle.
REQ-020 load while pending=1 overwrites the shadow (last write wins); each load produces its own load_ack.
REQ-021 On a tick with idx=3 (frame wrap): if pending=1, shadow->active and pending clears; frame_done pulses in the same cycle.
REQ-022 load coinciding with the frame-wrap tick: bcd_in goes directly to active, pending stays 0, and load_ack is still issued.
REQ-023 Active never changes mid-frame, so there is no display tearing.
REQ-024 bcd_err is recomputed at each shadow->active transfer: it is set if any active nibble is >9, else cleared.
REQ-025 blank_lz is sampled every cycle (it is not frame-latched).

Reset
REQ-026 On rst: prescaler=0, idx=0, active=16'h0000, shadow=16'h0000, pending=0.
REQ-027 Outputs under reset: dig_bcd=4'h0, digit_en_n=4'b1111, load_ack=0, frame_done=0, bcd_err=0.
REQ-028 After rst deasserts, the first tick occurs CLK_DIV cycles later; before that tick, digit_en_n[0]=0 showing "0".
REQ-029 rst asserted mid-frame or while pending discards the shadow with no partial transfer.

Structure
REQ-030 A shared package holds NUM_DIGITS, IDX_W=2, BCD_MAX=9 and the blank code constant.
REQ-031 One sub-module, scan_prescaler (parameter CLK_DIV; ports clk, rst, tick), holds the prescaler.
REQ-032 The BCD-to-7-segment decoder stays external, fed from dig_bcd.

Verification (CLK_DIV=4)
REQ-033 Reset release, then run 16 cycles -> idx sequence 0,1,2,3 at 4-cycle spacing; digit_en_n = 1110,1101,1011,0111; frame_done pulses once, at cycle 16.
REQ-034 load 16'h1234 mid-frame -> load_ack the next cycle; dig_bcd keeps showing 0 until the wrap, then shows 4,3,2,1.
REQ-035 load 16'h0007, then load 16'h0042 in the same frame -> after the wrap, display shows 42; two load_ack pulses.
REQ-036 blank_lz=1 with active 16'h0005 -> slots 1..3 give digit_en_n=1111; slot 0 gives 1110 with dig_bcd=5. Active 16'h0000 -> only slot 0 is lit, showing 0.
REQ-037 load 16'h12A4 -> at the wrap, bcd_err=1 and slot 1 is blanked; a later load of 16'h0001 clears bcd_err at the next wrap.
REQ-038 Pulse rst during slot 2 with pending=1 -> all registers return to reset values, and the next frame shows 0000.

Source files
------------

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants and helpers for the multiplexed BCD digit scanner.
// Slot math and blanking rules live here so the top stays readable.
package seg_scan_ctrl_pkg;

   localparam int NUM_DIGITS = 4;
   localparam int IDX_W = 2;
   localparam logic [3:0] BCD_MAX = 4'd9;
   localparam logic [3:0] BLANK_EN_N = 4'b1111;

   typedef logic [IDX_W-1:0] idx_t;

   // Nibble k of a packed four-digit value.
   function automatic logic [3:0] nib(
      input logic [15:0] v,
      input idx_t k
   );
      return v[{k, 2'b00} +: 4];
   endfunction

   // Code outside 0..9.
   function automatic logic nib_bad(input logic [3:0] n);
      return n > BCD_MAX;
   endfunction

   // Any of the four digits outside 0..9.
   function automatic logic has_bad(input logic [15:0] v);
      logic b;
      b = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (nib_bad(nib(v, idx_t'(i)))) b = 1'b1;
      end
      return b;
   endfunction

   // Slot k is dark when its code is invalid, or when it is a
   // leading zero (digits k..3 all zero) and k is not the units digit.
   function automatic logic slot_blank(
      input logic [15:0] v,
      input idx_t k,
      input logic lz
   );
      logic upper_nz;
      upper_nz = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (i >= int'(k) && nib(v, idx_t'(i)) != 4'h0) upper_nz = 1'b1;
      end
      return nib_bad(nib(v, k)) || (lz && k != '0 && !upper_nz);
   endfunction

endpackage

// File: rtl/seg_scan_ctrl_prescaler.sv
// Free-running divider: one-cycle tick every CLK_DIV clocks.
// Tick is asserted while the count sits at its terminal value.
module scan_prescaler #(
   parameter int CLK_DIV = 50000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Terminal-count detect and wrap.
   always_comb begin
      tick  = (cnt_q == LAST);
      cnt_d = tick ? '0 : cnt_q + CW'(1);
   end

   // Count register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed display scanner with double-buffered value.
// New values land in a shadow and move to the display only at frame wrap.
module seg_scan_ctrl
   import seg_scan_ctrl_pkg::*;
#(
   parameter int CLK_DIV = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] bcd_in,
   input  logic        blank_lz,
   output logic        load_ack,
   output logic [3:0]  dig_bcd,
   output logic [3:0]  digit_en_n,
   output logic        frame_done,
   output logic        bcd_err
);

   logic tick;

   idx_t        idx_q, idx_d;
   logic [15:0] active_q, active_d;
   logic [15:0] shadow_q, shadow_d;
   logic        pending_q, pending_d;
   logic        err_q, err_d;
   logic        ack_q, ack_d;
   logic        fd_q, fd_d;
   logic [3:0]  dig_q, dig_d;
   logic [3:0]  en_q, en_d;
   logic        wrap;
   logic [3:0]  code;

   scan_prescaler #(
      .CLK_DIV(CLK_DIV)
   ) u_presc (
      .clk (clk),
      .rst (rst),
      .tick(tick)
   );

   // Next state: slot advance, shadow capture, frame-boundary transfer,
   // and the pad drive for the slot that will be shown next cycle.
   always_comb begin
      idx_d     = idx_q;
      active_d  = active_q;
      shadow_d  = shadow_q;
      pending_d = pending_q;
      err_d     = err_q;
      wrap      = tick && (idx_q == idx_t'(NUM_DIGITS - 1));

      if (tick) idx_d = idx_q + idx_t'(1);

      if (load) begin
         shadow_d  = bcd_in;
         pending_d = 1'b1;
      end

      if (wrap) begin
         if (load) begin
            active_d  = bcd_in;
            pending_d = 1'b0;
            err_d     = has_bad(bcd_in);
         end else if (pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
            err_d     = has_bad(shadow_q);
         end
      end

      ack_d = load;
      fd_d  = wrap;
      code  = nib(active_d, idx_d);
      dig_d = nib_bad(code) ? 4'h0 : code;
      en_d  = slot_blank(active_d, idx_d, blank_lz)
              ? BLANK_EN_N : ~(4'b0001 << idx_d);
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q     <= '0;
         active_q  <= '0;
         shadow_q  <= '0;
         pending_q <= 1'b0;
         err_q     <= 1'b0;
         ack_q     <= 1'b0;
         fd_q      <= 1'b0;
         dig_q     <= 4'h0;
         en_q      <= BLANK_EN_N;
      end else begin
         idx_q     <= idx_d;
         active_q  <= active_d;
         shadow_q  <= shadow_d;
         pending_q <= pending_d;
         err_q     <= err_d;
         ack_q     <= ack_d;
         fd_q      <= fd_d;
         dig_q     <= dig_d;
         en_q      <= en_d;
      end
   end

   assign load_ack   = ack_q;
   assign dig_bcd    = dig_q;
   assign digit_en_n = en_q;
   assign frame_done = fd_q;
   assign bcd_err    = err_q;

endmodule
